marquee_seq: RTL and testbench
==============================

MARQUEE_SEQ -- requirements
Module: marquee_seq

Interface
REQ-001 Parameter W, default 3: operand width in bits; legal range 2..16.
REQ-002 Parameter DWELL_W, default 4: width of the dwell input.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 en  input  1: run enable; 0 freezes the sequencer and blocks input acceptance.
REQ-006 dir  input  1: step direction; 0 = ascending op index, 1 = descending.
REQ-007 op_mask  input  8: bit i set = op i is in the rotation.
REQ-008 dwell  input  DWELL_W: op i is applied to dwell+1 accepted transactions before advancing.
REQ-009 in_valid  input  1: indataA/indataB valid.
REQ-010 in_ready  output  1: block can accept.
REQ-011 indataA, indataB  input  W each: operands.
REQ-012 out_valid  output  1: outdata/op_idx valid.
REQ-013 out_ready  input  1: downstream accepts.
REQ-014 outdata  output  2W: registered result.
REQ-015 op_idx  output  3: op that produced outdata.

Function
REQ-016 Ops: 0 A|B, 1 A&B, 2 A^B, 3 {A,B}, 4 A+B, 5 A-B mod 2^(2W), 6 A*B, 7 ~(A^B) in W bits; all W-bit results zero-extended to 2W.
REQ-017 in_ready = en & (~out_valid | out_ready); accept = in_valid & in_ready.
REQ-018 Latency 1: outdata/op_idx load on accept; out_valid set on the next edge.
REQ-019 out_valid clears on out_valid & out_ready & ~accept; outdata holds while out_valid & ~out_ready.
REQ-020 Effective op = ptr if op_mask[ptr], else first set bit after ptr in dir order, wrapping 7->0 (ascending) or 0->7 (descending).
REQ-021 op_mask == 0: effective op is 0 (OR).
REQ-022 Per accept: dcnt == dwell -> dcnt = 0 and ptr = next set bit after effective op in dir order (wrap); else dcnt += 1 and ptr = effective op.
REQ-023 Single set bit in op_mask: ptr stays on that op indefinitely.
REQ-024 dwell, dir and op_mask sampled per accept; changes between accepts take effect on the next accept with no glitch on outputs.
REQ-025 dwell lowered below current dcnt: next accept treats dcnt >= dwell as terminal and advances.
REQ-026 en = 0: ptr, dcnt frozen; a pending out_valid still drains via out_ready.
REQ-027 Simultaneous drain and accept: out_valid stays 1; outdata takes the new result.

Reset
REQ-028 On rst low, asynchronously: outdata = 0, op_idx = 0, out_valid = 0, ptr = 0, dcnt = 0.
REQ-029 in_ready = 0 while rst is low; reset mid-transaction discards the pending result.
REQ-030 Deassertion of rst requires no synchroniser inside the block; the first accept is allowed on the first rising edge after release.

Structure
REQ-031 Package marquee_pkg holds: op-code enum (8 entries), NUM_OPS = 8, and the masked next-set-bit search function (ptr, mask, dir).
REQ-032 Sub-module marquee_alu: purely combinational, parametrised W, maps (op, A, B) to a 2W-bit result; marquee_seq instantiates one.
REQ-033 Sequencer (ptr, dcnt) and output register live in marquee_seq.

Verification
REQ-034 W=3, mask=8'h0F, dwell=0, dir=0, out_ready=1, A=3'b101, B=3'b011 each cycle -> outdata 7,1,6,43 repeating; op_idx 0,1,2,3.
REQ-035 mask=8'hFF, dwell=2, dir=1, continuous valid -> op_idx 0,0,0,7,7,7,6,6,6,...
REQ-036 W=4, ops 4,5,6, A=4'hF, B=4'h1 -> outdata 8'h10, 8'h0E, 8'h0F.
REQ-037 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outdata/op_idx stable, ptr unchanged; out_ready=1 resumes with no lost or duplicated results.
REQ-038 mask=8'h00 -> every result is A|B, op_idx=0; mask changed 8'h01->8'h20 mid-run -> next accept uses op 5.
REQ-039 rst asserted with out_valid=1 and dcnt=1 -> out_valid=0, outdata=0 immediately; first post-reset result uses op 0 (if mask[0]=1) with a full dwell.

Source files
------------

// File: rtl/marquee_pkg.sv
// Shared op-code definitions and the masked rotation search used by the marquee sequencer.
package marquee_pkg;

  localparam int NUM_OPS = 8;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_CAT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  // First set mask bit strictly after ptr in dir order, wrapping; a lone set bit finds itself.
  // Scanning from the farthest step down leaves the nearest hit in res.
  function automatic logic [2:0] next_set_bit(input logic [2:0] ptr,
                                              input logic [7:0] mask,
                                              input logic       dir);
    logic [2:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = NUM_OPS; k >= 1; k--) begin
      idx = dir ? (ptr - 3'(k)) : (ptr + 3'(k));
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/marquee_seq_if.sv
// Valid/ready operand and result stream of the marquee sequencer.
interface marquee_seq_if #(parameter int W = 3);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   indataA;
  logic [W-1:0]   indataB;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] outdata;
  logic [2:0]     op_idx;

  modport master (
    output in_valid, indataA, indataB, out_ready,
    input  in_ready, out_valid, outdata, op_idx
  );

  modport slave (
    input  in_valid, indataA, indataB, out_ready,
    output in_ready, out_valid, outdata, op_idx
  );
endinterface

// File: rtl/marquee_alu.sv
// Combinational op evaluator: maps (op, A, B) to a 2W-bit result, W-bit results zero-extended.
module marquee_alu
  import marquee_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [2:0]     op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] res_o
);

  logic [2*W-1:0] a_x;
  logic [2*W-1:0] b_x;

  assign a_x = {{W{1'b0}}, a_i};
  assign b_x = {{W{1'b0}}, b_i};

  always_comb begin
    res_o = '0;
    case (op_e'(op_i))
      OP_OR:   res_o = {{W{1'b0}}, a_i | b_i};
      OP_AND:  res_o = {{W{1'b0}}, a_i & b_i};
      OP_XOR:  res_o = {{W{1'b0}}, a_i ^ b_i};
      OP_CAT:  res_o = {a_i, b_i};
      OP_ADD:  res_o = a_x + b_x;
      OP_SUB:  res_o = a_x - b_x;
      OP_MUL:  res_o = a_x * b_x;
      OP_XNOR: res_o = {{W{1'b0}}, ~(a_i ^ b_i)};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/marquee_seq.sv
// Rotating-op stream processor: each accepted operand pair is combined by the current op,
// and the op pointer walks the enabled ops after dwell+1 transactions on each.
module marquee_seq
  import marquee_pkg::*;
#(
  parameter int W       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [7:0]         op_mask,
  input  logic [DWELL_W-1:0] dwell,
  marquee_seq_if.slave       bus
);

  logic [2:0]         ptr_q, ptr_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [2*W-1:0]     outdata_q, outdata_d;
  logic [2:0]         op_idx_q, op_idx_d;

  logic [2:0]         eff_op;
  logic [2*W-1:0]     alu_res;
  logic               in_ready;
  logic               accept;

  marquee_alu #(.W(W)) u_alu (
    .op_i  (eff_op),
    .a_i   (bus.indataA),
    .b_i   (bus.indataB),
    .res_o (alu_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      dcnt_q      <= '0;
      out_valid_q <= 1'b0;
      outdata_q   <= '0;
      op_idx_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
      out_valid_q <= out_valid_d;
      outdata_q   <= outdata_d;
      op_idx_q    <= op_idx_d;
    end
  end

  // dcnt >= dwell (not ==) so a dwell lowered under the running count still terminates.
  always_comb begin
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_q;
    outdata_d   = outdata_q;
    op_idx_d    = op_idx_q;
    out_valid_d = accept | (out_valid_q & ~bus.out_ready);
    if (accept) begin
      outdata_d = alu_res;
      op_idx_d  = eff_op;
      if (dcnt_q >= dwell) begin
        dcnt_d = '0;
        ptr_d  = next_set_bit(eff_op, op_mask, dir);
      end else begin
        dcnt_d = dcnt_q + DWELL_W'(1);
        ptr_d  = eff_op;
      end
    end
  end

  // An empty mask falls back to op 0 through next_set_bit's default.
  always_comb begin
    eff_op   = op_mask[ptr_q] ? ptr_q : next_set_bit(ptr_q, op_mask, dir);
    in_ready = rst & en & (~out_valid_q | bus.out_ready);
    accept   = bus.in_valid & in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.outdata   = outdata_q;
  assign bus.op_idx    = op_idx_q;

endmodule

// File: tb/tb_marquee_seq.sv
// Bench for marquee_seq: directed table, hand sequences and random traffic against a reference model.
module tb_marquee_seq;

  localparam int W  = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, dir = 1'b0;
  logic [7:0]    mask = 8'h00;
  logic [DW-1:0] dwell = '0;
  logic          en4 = 1'b0, dir4 = 1'b0;
  logic [7:0]    mask4 = 8'h00;
  logic [DW-1:0] dwell4 = '0;

  marquee_seq_if #(.W(3)) b3 ();
  marquee_seq_if #(.W(4)) b4 ();

  marquee_seq #(.W(3), .DWELL_W(DW)) dut3 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .op_mask(mask), .dwell(dwell), .bus(b3));

  marquee_seq #(.W(4), .DWELL_W(DW)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .dir(dir4), .op_mask(mask4), .dwell(dwell4), .bus(b4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ptr, m_dcnt, m_data, m_op;
  bit m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_after(int p, logic [7:0] m, logic d);
    for (int s = 1; s <= 8; s++) begin
      int q;
      q = d ? (p - s + 8) % 8 : (p + s) % 8;
      if (m[q]) return q;
    end
    return 0;
  endfunction

  function automatic int eff_of(int p, logic [7:0] m, logic d);
    if (m == 8'h00) return 0;
    if (m[p]) return p;
    return next_after(p, m, d);
  endfunction

  function automatic int alu_ref(int op, int a, int b, int w);
    int full, half;
    full = 1 << (2 * w);
    half = 1 << w;
    case (op)
      0: return a | b;
      1: return a & b;
      2: return a ^ b;
      3: return a * half + b;
      4: return (a + b) % full;
      5: return (a - b + full) % full;
      6: return (a * b) % full;
      default: return (half - 1) & ~(a ^ b);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_dcnt = 0; m_valid = 0; m_data = 0; m_op = 0;
  endtask

  // One cycle: check outputs at negedge, then advance the model across the rising edge.
  task automatic step();
    bit exp_rdy, acc;
    int e;
    @(negedge clk);
    exp_rdy = rst && en && (!m_valid || b3.out_ready);
    chk("in_ready", b3.in_ready, exp_rdy);
    chk("out_valid", b3.out_valid, m_valid);
    if (m_valid) begin
      chk("outdata", b3.outdata, m_data);
      chk("op_idx", b3.op_idx, m_op);
    end
    acc = b3.in_valid && exp_rdy;
    @(posedge clk);
    if (acc) begin
      e       = eff_of(m_ptr, mask, dir);
      m_data  = alu_ref(e, b3.indataA, b3.indataB, W);
      m_op    = e;
      m_valid = 1;
      if (m_dcnt >= dwell) begin
        m_dcnt = 0;
        m_ptr  = next_after(e, mask, dir);
      end else begin
        m_dcnt++;
        m_ptr = e;
      end
    end else if (m_valid && b3.out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit en; bit iv; bit ordy;
    bit ev; int ed; int eo;
  } vec_t;

  vec_t tbl[14];
  int   exp35[9] = '{0, 0, 0, 7, 7, 7, 6, 6, 6};
  int   exp39[3] = '{0, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    b3.in_valid = 0; b3.indataA = '0; b3.indataB = '0; b3.out_ready = 0;
    b4.in_valid = 0; b4.indataA = '0; b4.indataB = '0; b4.out_ready = 1;
    model_reset();

    tbl[0]  = '{1,1,1, 1, 7,0};
    tbl[1]  = '{1,1,1, 1, 1,1};
    tbl[2]  = '{1,1,1, 1, 6,2};
    tbl[3]  = '{1,1,1, 1,43,3};
    tbl[4]  = '{1,1,1, 1, 7,0};
    tbl[5]  = '{1,1,1, 1, 1,1};
    tbl[6]  = '{1,1,1, 1, 6,2};
    tbl[7]  = '{1,1,1, 1,43,3};
    tbl[8]  = '{1,1,0, 1,43,3};
    tbl[9]  = '{1,1,0, 1,43,3};
    tbl[10] = '{1,1,1, 1, 7,0};
    tbl[11] = '{0,1,1, 0, 0,0};
    tbl[12] = '{1,1,1, 1, 1,1};
    tbl[13] = '{1,0,1, 0, 0,0};

    #12;
    chk("reset out_valid", b3.out_valid, 0);
    chk("reset outdata", b3.outdata, 0);
    chk("reset op_idx", b3.op_idx, 0);
    en = 1;
    chk("reset in_ready", b3.in_ready, 0);
    do_reset();

    // Fixed-operand rotation over ops 0..3 with stalls and an enable gap.
    mask = 8'h0F; dwell = 0; dir = 0;
    b3.indataA = 3'b101; b3.indataB = 3'b011;
    foreach (tbl[i]) begin
      en = tbl[i].en; b3.in_valid = tbl[i].iv; b3.out_ready = tbl[i].ordy;
      @(posedge clk);
      @(negedge clk);
      chk("tbl out_valid", b3.out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl outdata", b3.outdata, tbl[i].ed);
        chk("tbl op_idx", b3.op_idx, tbl[i].eo);
      end
    end
    b3.in_valid = 0;

    // W=4 arithmetic ops selected by moving a single mask bit.
    do_reset();
    en4 = 1; b4.in_valid = 1; b4.indataA = 4'hF; b4.indataB = 4'h1;
    mask4 = 8'h10;
    @(posedge clk); @(negedge clk);
    chk("w4 add", b4.outdata, 8'h10); chk("w4 add op", b4.op_idx, 4);
    mask4 = 8'h20;
    @(posedge clk); @(negedge clk);
    chk("w4 sub", b4.outdata, 8'h0E); chk("w4 sub op", b4.op_idx, 5);
    mask4 = 8'h40;
    @(posedge clk); @(negedge clk);
    chk("w4 mul", b4.outdata, 8'h0F); chk("w4 mul op", b4.op_idx, 6);
    b4.in_valid = 0;

    // Descending rotation with dwell 2.
    do_reset();
    en = 1; mask = 8'hFF; dwell = 2; dir = 1;
    b3.in_valid = 1; b3.out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      b3.indataA = 3'($urandom); b3.indataB = 3'($urandom);
      step();
      chk("desc op_idx", b3.op_idx, exp35[i]);
    end

    // Output stall for 5 cycles, then resume.
    b3.out_ready = 0;
    for (int i = 0; i < 5; i++) step();
    b3.out_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Empty mask, then a mask swap mid-run.
    mask = 8'h00; dwell = 0; dir = 0;
    for (int i = 0; i < 4; i++) begin
      b3.indataA = 3'($urandom); b3.indataB = 3'($urandom);
      step();
    end
    mask = 8'h01;
    step(); step();
    mask = 8'h20;
    step();
    chk("mask swap op", b3.op_idx, 5);

    // Reset in the middle of a dwell with a result pending.
    mask = 8'h01; dwell = 3;
    step();
    b3.in_valid = 0; b3.out_ready = 0;
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", b3.out_valid, 0);
    chk("async outdata", b3.outdata, 0);
    chk("async in_ready", b3.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    mask = 8'h03; dwell = 1; b3.in_valid = 1; b3.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-reset op", b3.op_idx, exp39[i]);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      b3.in_valid  = 1'($urandom);
      b3.out_ready = ($urandom_range(9, 0) < 7);
      b3.indataA   = 3'($urandom);
      b3.indataB   = 3'($urandom);
      en           = ($urandom_range(19, 0) < 17);
      if ($urandom_range(15, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: mask = 8'h00;
          1: mask = 8'h01 << $urandom_range(7, 0);
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(11, 0) == 0) dwell = DW'($urandom_range(3, 0));
      if ($urandom_range(23, 0) == 0) dir = ~dir;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
